oam_dma: RTL and testbench
==========================

# oam_dma

CPU-bus master that performs the $4014 sprite DMA. It snoops CPU writes to $4014, then halts the CPU and copies the 256-byte page $XX00–$XXFF to PPU OAMDATA ($2004). It does this with alternating read/write cycles on the CPU bus. It sits beside CPU_2A03 in the NES top level, and its bus outputs are muxed over the CPU's address/data/RW when DMA_ACTIVE is high.

## Interface
Parameters:
- XFER_LEN, 256, bytes per transfer; the low address byte counts 0..XFER_LEN-1.

Ports:
- CLK  in  1  CPU clock; the same clock as CPU_2A03.
- RESET  in  1  Synchronous, active-high reset. This is the block's one clock domain.
- ENABLE  in  1  Clock enable, shared with the CPU. When low, all state, including cycle parity, holds.
- CPU_ADDR  in  16  Address driven by the CPU core.
- CPU_DATA_OUT  in  8  CPU write data.
- CPU_RW_n  in  1  CPU read/write strobe; 0 = write.
- BUS_DATA_IN  in  8  Selected CPU data bus (read data), valid by the end of the cycle.
- DMA_ACTIVE  out  1  The DMA owns the bus and the CPU is halted. The top uses it to gate the CPU ENABLE and to select the DMA outputs onto the bus.
- DMA_ADDR  out  16  Address driven while DMA_ACTIVE.
- DMA_DATA_OUT  out  8  Write data driven while DMA_ACTIVE.
- DMA_RW_n  out  1  Read/write strobe driven while DMA_ACTIVE; 0 = write.

## Operation
- States: IDLE, HALT, ALIGN, READ, WRITE.
  - All outputs are Moore-decoded from registered state.
  - Registers: page[7:0], cnt[7:0], latch[7:0] and parity.
- parity: a flop that toggles on every enabled CLK. It resets to 0.
- Trigger condition: IDLE && ENABLE && CPU_RW_n==0 && CPU_ADDR==16'h4014.
  - On the trigger edge: page <= CPU_DATA_OUT, cnt <= 0, state -> HALT.
- HALT: a dummy cycle.
  - If parity==1, go to READ; else go to ALIGN.
  - This guarantees READ always lands on parity==0.
- ALIGN: a dummy cycle, then go to READ.
- READ:
  - DMA_ADDR={page,cnt}, DMA_RW_n=1.
  - At the closing edge, latch <= BUS_DATA_IN; go to WRITE.
- WRITE:
  - DMA_ADDR=16'h2004, DMA_RW_n=0, DMA_DATA_OUT=latch.
  - At the closing edge, cnt <= cnt+1 (8-bit wrap).
  - If cnt==XFER_LEN-1, go to IDLE; else go to READ.
- Dummy cycles (HALT/ALIGN) drive DMA_ADDR={page,cnt} with DMA_RW_n=1. Read data from these cycles is discarded.
- DMA_ACTIVE=1 in every state except IDLE.
- In IDLE: DMA_ADDR=16'h0000, DMA_RW_n=1, DMA_DATA_OUT=latch.
- Any page is legal, including $20 (PPU registers are read as-is) and $FF (reads run up to $FFFF with no carry into page).
- A $4014 write seen while not IDLE is ignored. It cannot normally occur, because the CPU is halted.

## Timing
- Reset values: state=IDLE, parity=0, page=0, cnt=0, latch=0.
  - Outputs on reset: DMA_ACTIVE=0, DMA_ADDR=16'h0000, DMA_DATA_OUT=8'h00, DMA_RW_n=1.
- DMA_ACTIVE rises in the first cycle after the trigger cycle. The trigger write itself completes as a normal CPU write.
- Total halted cycles:
  - 513 when the HALT cycle has parity 1.
  - 514 when the HALT cycle has parity 0.
- Byte n is read in READ cycle n and written in the immediately following WRITE cycle. Read-to-write latency is 1 cycle.
- DMA_ACTIVE falls in the cycle after the 256th WRITE. The CPU resumes in that cycle.
- ENABLE low mid-transfer: everything freezes and the current outputs are held. Cycle counts are measured in enabled cycles.
- RESET mid-transfer: state is IDLE from the next edge.
  - No further $2004 writes occur.
  - The partial OAM contents are left as they are.
- Reset and trigger in the same cycle: reset wins and no transfer starts.

## Structure
- nes_pkg holds:
  - the state enum typedef oam_dma_state_t;
  - constants OAMDMA_REG_ADDR=16'h4014 and OAMDATA_ADDR=16'h2004.
- The block is a single flat module with no sub-module. The parity flop and the counter are inline.
- The top-level CPU bus selection adds a DMA_ACTIVE mux ahead of the existing address decode. The existing decode then routes $2004 writes to the PPU unchanged.

## Test plan
- Basic transfer:
  - Stimulus: SYS_RAM $0200–$02FF preloaded with value=index; write $02 to $4014 with HALT landing on parity 1.
  - Required: exactly 513 DMA_ACTIVE cycles; 256 writes to $2004 carrying 00..FF in order; READ addresses $0200..$02FF.
- Alignment:
  - Stimulus: the same transfer, triggered one cycle later so HALT lands on parity 0.
  - Required: exactly 514 DMA_ACTIVE cycles; first READ is on parity 0; data is identical.
- Page $FF:
  - Stimulus: PRG_ROM $FF00–$FFFF preloaded with ~index.
  - Required: writes FF..00; last read address is $FFFF; DMA_ACTIVE falls with no extra cycles.
- Reset mid-transfer:
  - Stimulus: assert RESET after the 100th WRITE.
  - Required: DMA_ACTIVE=0, DMA_RW_n=1 and DMA_ADDR=0 on the next cycle; no further $2004 writes; a subsequent $4014 write runs a full 256-byte transfer.
- ENABLE stall:
  - Stimulus: drop ENABLE for 5 cycles during a READ.
  - Required: DMA_ADDR and latch hold; the transfer resumes; the total enabled active count is still 513 or 514.
- Non-trigger writes:
  - Stimulus: CPU writes to $4015 and $4016, and a read of $4014.
  - Required: DMA_ACTIVE stays 0; page and cnt are unchanged.

Source files
------------

// File: rtl/nes_pkg.sv
// -----------------------------------------------------------------------------
// nes_pkg
// Shared types and constants for the NES CPU-side blocks.
//   oam_dma_state_t  : sprite DMA sequencer states
//   OAMDMA_REG_ADDR  : CPU address whose write starts a sprite DMA ($4014)
//   OAMDATA_ADDR     : PPU OAM data port the DMA writes into ($2004)
// -----------------------------------------------------------------------------
package nes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } oam_dma_state_t;

  localparam logic [15:0] OAMDMA_REG_ADDR = 16'h4014;
  localparam logic [15:0] OAMDATA_ADDR    = 16'h2004;

endpackage

// File: rtl/oam_dma.sv
// -----------------------------------------------------------------------------
// oam_dma
// Sprite DMA bus master. Snoops CPU writes to $4014, halts the CPU and copies
// page $XX00-$XXFF into PPU OAMDATA ($2004) with alternating read/write bus
// cycles. All outputs are decoded from registered state.
//
// Ports
//   CLK           in   CPU clock
//   RESET         in   synchronous, active-high reset
//   ENABLE        in   clock enable shared with the CPU; low freezes all state
//   CPU_ADDR      in   [15:0] address from the CPU core (snooped)
//   CPU_DATA_OUT  in   [7:0]  CPU write data (snooped, gives the page)
//   CPU_RW_n      in   CPU read/write strobe, 0 = write
//   BUS_DATA_IN   in   [7:0]  selected CPU read data, valid by cycle end
//   DMA_ACTIVE    out  DMA owns the bus, CPU halted
//   DMA_ADDR      out  [15:0] address driven while active
//   DMA_DATA_OUT  out  [7:0]  write data driven while active
//   DMA_RW_n      out  read/write strobe driven while active, 0 = write
//   dbg_state     out  current sequencer state
//
// Bus handshake: there is no stall handshake on the bus; a bus cycle completes
// on every CLK edge where ENABLE is high, and nothing moves otherwise.
// -----------------------------------------------------------------------------
module oam_dma
  import nes_pkg::*;
#(
  parameter int XFER_LEN = 256
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           ENABLE,
  input  logic [15:0]    CPU_ADDR,
  input  logic [7:0]     CPU_DATA_OUT,
  input  logic           CPU_RW_n,
  input  logic [7:0]     BUS_DATA_IN,
  output logic           DMA_ACTIVE,
  output logic [15:0]    DMA_ADDR,
  output logic [7:0]     DMA_DATA_OUT,
  output logic           DMA_RW_n,
  output oam_dma_state_t dbg_state
);

  localparam logic [7:0] LAST_CNT = 8'(XFER_LEN - 1);

  oam_dma_state_t state_q, state_d;
  logic [7:0]     page_q;
  logic [7:0]     cnt_q;
  logic [7:0]     latch_q;
  logic           parity_q;
  logic           trigger;

  // A $4014 write only counts while idle; while busy the CPU is halted anyway.
  assign trigger = (state_q == ST_IDLE) && ENABLE && !CPU_RW_n &&
                   (CPU_ADDR == OAMDMA_REG_ADDR);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      parity_q <= 1'b0;
      page_q   <= 8'h00;
      cnt_q    <= 8'h00;
      latch_q  <= 8'h00;
    end else if (ENABLE) begin
      state_q  <= state_d;
      parity_q <= ~parity_q;
      if (trigger) begin
        page_q <= CPU_DATA_OUT;
        cnt_q  <= 8'h00;
      end
      if (state_q == ST_READ) begin
        latch_q <= BUS_DATA_IN;
      end
      // 8-bit wrap: page never carries, so page $FF stops at $FFFF.
      if (state_q == ST_WRITE) begin
        cnt_q <= cnt_q + 8'h01;
      end
    end
  end

  // Next state. HALT picks ALIGN when needed so READ always lands on parity 0.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (trigger) state_d = ST_HALT;
      ST_HALT:  state_d = parity_q ? ST_READ : ST_ALIGN;
      ST_ALIGN: state_d = ST_READ;
      ST_READ:  state_d = ST_WRITE;
      ST_WRITE: state_d = (cnt_q == LAST_CNT) ? ST_IDLE : ST_READ;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Moore outputs. Dummy cycles present {page,cnt} as a harmless read.
  always_comb begin
    DMA_ACTIVE   = (state_q != ST_IDLE);
    DMA_ADDR     = {page_q, cnt_q};
    DMA_RW_n     = 1'b1;
    DMA_DATA_OUT = latch_q;
    case (state_q)
      ST_IDLE: begin
        DMA_ADDR = 16'h0000;
      end
      ST_WRITE: begin
        DMA_ADDR = OAMDATA_ADDR;
        DMA_RW_n = 1'b0;
      end
      default: begin
        DMA_ADDR = {page_q, cnt_q};
      end
    endcase
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_oam_dma.sv
// -----------------------------------------------------------------------------
// tb_oam_dma
// Self-checking bench for oam_dma. A 64 KiB memory model answers DMA reads;
// expected read addresses and $2004 write data are queued when a transfer is
// triggered and popped as the DMA produces bus cycles.
// -----------------------------------------------------------------------------
module tb_oam_dma;
  import nes_pkg::*;

  logic           CLK;
  logic           RESET;
  logic           ENABLE;
  logic [15:0]    CPU_ADDR;
  logic [7:0]     CPU_DATA_OUT;
  logic           CPU_RW_n;
  logic [7:0]     BUS_DATA_IN;
  logic           DMA_ACTIVE;
  logic [15:0]    DMA_ADDR;
  logic [7:0]     DMA_DATA_OUT;
  logic           DMA_RW_n;
  oam_dma_state_t dbg_state;

  oam_dma #(.XFER_LEN(256)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .ENABLE       (ENABLE),
    .CPU_ADDR     (CPU_ADDR),
    .CPU_DATA_OUT (CPU_DATA_OUT),
    .CPU_RW_n     (CPU_RW_n),
    .BUS_DATA_IN  (BUS_DATA_IN),
    .DMA_ACTIVE   (DMA_ACTIVE),
    .DMA_ADDR     (DMA_ADDR),
    .DMA_DATA_OUT (DMA_DATA_OUT),
    .DMA_RW_n     (DMA_RW_n),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- memory model ----------------
  logic [7:0] mem [0:65535];
  assign BUS_DATA_IN = mem[DMA_ADDR];

  // Cycle parity reference: toggles on each enabled edge, cleared by reset.
  logic tb_par;
  always @(posedge CLK) begin
    if (RESET) tb_par <= 1'b0;
    else if (ENABLE) tb_par <= ~tb_par;
  end

  // ---------------- scoreboard ----------------
  logic [7:0]  exp_q[$];
  logic [15:0] exp_addr_q[$];
  int checks = 0;
  int errors = 0;
  int act_cnt = 0;
  int wr_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, only for cycles that will complete.
  always @(negedge CLK) begin
    if (ENABLE) begin
      if (DMA_ACTIVE) act_cnt++;
      if (!DMA_ACTIVE) begin
        check("idle_addr", {16'h0, DMA_ADDR}, 32'h0);
        check("idle_rw", {31'h0, DMA_RW_n}, 32'h1);
      end
      if (DMA_ACTIVE && dbg_state == ST_READ) begin
        check("rd_parity", {31'h0, tb_par}, 32'h0);
        check("rd_rw", {31'h0, DMA_RW_n}, 32'h1);
        if (exp_addr_q.size() == 0) check("rd_unexpected", {16'h0, DMA_ADDR}, 32'hFFFFFFFF);
        else check("rd_addr", {16'h0, DMA_ADDR}, {16'h0, exp_addr_q.pop_front()});
      end
      if (DMA_ACTIVE && !DMA_RW_n) begin
        wr_cnt++;
        check("wr_addr", {16'h0, DMA_ADDR}, {16'h0, OAMDATA_ADDR});
        if (exp_q.size() == 0) check("wr_unexpected", {24'h0, DMA_DATA_OUT}, 32'hFFFFFFFF);
        else check("wr_data", {24'h0, DMA_DATA_OUT}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cpu_idle();
    CPU_ADDR     = 16'h0000;
    CPU_DATA_OUT = 8'h00;
    CPU_RW_n     = 1'b1;
  endtask

  // Trigger a DMA of 'page' so the HALT cycle has parity 'halt_par'.
  task automatic start_dma(input logic [7:0] page, input logic halt_par);
    int n = 0;
    do begin
      @(posedge CLK); #1;
      n++;
    end while (tb_par != ~halt_par && n < 10);
    CPU_ADDR     = OAMDMA_REG_ADDR;
    CPU_DATA_OUT = page;
    CPU_RW_n     = 1'b0;
    for (int i = 0; i < 256; i++) begin
      exp_addr_q.push_back({page, 8'(i)});
      exp_q.push_back(mem[{page, 8'(i)}]);
    end
    act_cnt = 0;
    @(posedge CLK); #1;
    cpu_idle();
    @(negedge CLK);
    check("active_rise", {31'h0, DMA_ACTIVE}, 32'h1);
  endtask

  task automatic wait_done(input int exp_cycles);
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (DMA_ACTIVE && n < 3000);
    check("done_timeout", {31'h0, DMA_ACTIVE}, 32'h0);
    check("active_cycles", act_cnt, exp_cycles);
    check("wr_q_empty", exp_q.size(), 0);
    check("rd_q_empty", exp_addr_q.size(), 0);
  endtask

  task automatic cpu_access(input logic [15:0] a, input logic [7:0] d, input logic rw);
    @(posedge CLK); #1;
    CPU_ADDR = a; CPU_DATA_OUT = d; CPU_RW_n = rw;
    @(posedge CLK); #1;
    cpu_idle();
    @(negedge CLK);
    check("no_trigger", {31'h0, DMA_ACTIVE}, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] held;
    int base;
    int n;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 256; i++) begin
      mem[16'h0200 + i] = 8'(i);
      mem[16'hFF00 + i] = ~8'(i);
      mem[16'h0300 + i] = 8'($urandom_range(0, 255));
    end
    RESET = 1'b1;
    ENABLE = 1'b1;
    cpu_idle();
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    check("rst_active", {31'h0, DMA_ACTIVE}, 32'h0);
    check("rst_addr", {16'h0, DMA_ADDR}, 32'h0);
    check("rst_data", {24'h0, DMA_DATA_OUT}, 32'h0);
    check("rst_rw", {31'h0, DMA_RW_n}, 32'h1);

    // Non-trigger accesses
    cpu_access(16'h4015, 8'h5A, 1'b0);
    cpu_access(16'h4016, 8'hA5, 1'b0);
    cpu_access(16'h4014, 8'h07, 1'b1);

    // Basic transfer, HALT on parity 1
    start_dma(8'h02, 1'b1);
    wait_done(513);
    // Alignment: HALT on parity 0
    start_dma(8'h02, 1'b0);
    wait_done(514);
    // Page $FF
    start_dma(8'hFF, 1'b1);
    wait_done(513);

    // ENABLE stall during a READ
    start_dma(8'h03, 1'b0);
    n = 0;
    do begin
      @(posedge CLK); #1;
      n++;
    end while (!(dbg_state == ST_READ && wr_cnt % 256 >= 20) && n < 2000);
    check("stall_reach", {31'h0, dbg_state == ST_READ}, 32'h1);
    ENABLE = 1'b0;
    held = DMA_ADDR;
    repeat (5) begin
      @(negedge CLK);
      check("stall_addr", {16'h0, DMA_ADDR}, {16'h0, held});
      check("stall_rw", {31'h0, DMA_RW_n}, 32'h1);
    end
    @(posedge CLK); #1;
    ENABLE = 1'b1;
    wait_done(514);

    // Reset after the 100th write
    start_dma(8'h02, 1'b1);
    base = wr_cnt;
    n = 0;
    while (wr_cnt < base + 100 && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    check("rst_reach", wr_cnt - base, 100);
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    exp_q.delete();
    exp_addr_q.delete();
    @(negedge CLK);
    check("midrst_active", {31'h0, DMA_ACTIVE}, 32'h0);
    check("midrst_rw", {31'h0, DMA_RW_n}, 32'h1);
    check("midrst_addr", {16'h0, DMA_ADDR}, 32'h0);
    base = wr_cnt;
    repeat (10) @(negedge CLK);
    check("midrst_no_wr", wr_cnt - base, 0);
    start_dma(8'h03, 1'b1);
    wait_done(513);

    // Reset and trigger in the same cycle
    @(posedge CLK); #1;
    RESET = 1'b1;
    CPU_ADDR = OAMDMA_REG_ADDR; CPU_DATA_OUT = 8'h02; CPU_RW_n = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b0;
    cpu_idle();
    @(negedge CLK);
    check("rst_trig_active", {31'h0, DMA_ACTIVE}, 32'h0);
    repeat (3) @(negedge CLK);
    check("rst_trig_idle", {31'h0, DMA_ACTIVE}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
